// File: rtl/pool_window_gen_if.sv
// Stream-side bundle for the 2x2 pooling window generator: pixel beats in,
// four-word windows plus strobes out.
interface pool_window_gen_if #(
  parameter int data_width = 32
);
  logic [data_width-1:0] data_in;
  logic                  valid_in;
  logic [data_width-1:0] Out1;
  logic [data_width-1:0] Out2;
  logic [data_width-1:0] Out3;
  logic [data_width-1:0] Out4;
  logic                  valid_out;
  logic                  frame_done;

  modport master (
    output data_in, valid_in,
    input  Out1, Out2, Out3, Out4, valid_out, frame_done
  );

  modport slave (
    input  data_in, valid_in,
    output Out1, Out2, Out3, Out4, valid_out, frame_done
  );
endinterface

// File: rtl/pool_window_gen.sv
// Gathers non-overlapping 2x2 windows (stride 2) from a raster pixel stream,
// using a one-row line buffer plus a single held pixel for the bottom-left.
module pool_window_gen #(
  parameter int data_width = 32,
  parameter int img_width  = 28,
  parameter int img_height = 28
) (
  input  logic             clk,
  input  logic             reset,
  pool_window_gen_if.slave bus
);

  localparam int col_w = (img_width  > 2) ? $clog2(img_width)  : 1;
  localparam int row_w = (img_height > 2) ? $clog2(img_height) : 1;
  localparam logic [col_w-1:0] col_last = col_w'(img_width - 1);
  localparam logic [row_w-1:0] row_last = row_w'(img_height - 1);

  typedef logic [3:0][data_width-1:0] window_t;

  logic [col_w-1:0]      col_cnt_q, col_cnt_d;
  logic [row_w-1:0]      row_cnt_q, row_cnt_d;
  logic [data_width-1:0] prev_pix_q, prev_pix_d;
  window_t               win_q, win_d;
  logic                  valid_out_q, valid_out_d;
  logic                  frame_done_q, frame_done_d;
  logic                  lb_we;
  logic [col_w-1:0]      left_col;
  logic [data_width-1:0] linebuf_q [img_width];

  assign left_col = col_cnt_q - col_w'(1);

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    col_cnt_d    = col_cnt_q;
    row_cnt_d    = row_cnt_q;
    prev_pix_d   = prev_pix_q;
    win_d        = win_q;
    valid_out_d  = 1'b0;
    frame_done_d = 1'b0;
    lb_we        = 1'b0;

    if (bus.valid_in) begin
      if (!row_cnt_q[0]) begin
        lb_we = 1'b1;
      end else if (!col_cnt_q[0]) begin
        prev_pix_d = bus.data_in;
      end else begin
        win_d        = {bus.data_in, prev_pix_q, linebuf_q[col_cnt_q], linebuf_q[left_col]};
        valid_out_d  = 1'b1;
        frame_done_d = (row_cnt_q == row_last) && (col_cnt_q == col_last);
      end

      if (col_cnt_q == col_last) begin
        col_cnt_d = '0;
        row_cnt_d = (row_cnt_q == row_last) ? '0 : row_cnt_q + row_w'(1);
      end else begin
        col_cnt_d = col_cnt_q + col_w'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_cnt_q    <= '0;
      row_cnt_q    <= '0;
      prev_pix_q   <= '0;
      win_q        <= '0;
      valid_out_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      row_cnt_q    <= row_cnt_d;
      prev_pix_q   <= prev_pix_d;
      win_q        <= win_d;
      valid_out_q  <= valid_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  // NOTE: the line buffer has no reset; every entry is written on an even row
  // before the following odd row reads it, so clearing it buys nothing.
  always_ff @(posedge clk) begin
    if (lb_we) begin
      linebuf_q[col_cnt_q] <= bus.data_in;
    end
  end

  assign bus.Out1       = win_q[0];
  assign bus.Out2       = win_q[1];
  assign bus.Out3       = win_q[2];
  assign bus.Out4       = win_q[3];
  assign bus.valid_out  = valid_out_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: doc/pool_window_gen.md
Name: pool_window_gen

Overview:
- Producer side of the 2x2 max-pool interface. Takes a raster-order feature-map pixel stream, one pixel per valid beat.
- Emits non-overlapping 2x2 windows (stride 2) as four parallel words plus a valid strobe. These drive the four-input max-pool stage directly.
- Sits between a conv/activation output stream and the max-pool stage, one instance per channel.

Parameters:
- data_width, 32, pixel word width.
- img_width, 28, pixels per row. Must be even and >= 2.
- img_height, 28, rows per frame. Must be even and >= 2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (reset==0 resets).
- data_in  input  data_width  pixel, raster order, row-major.
- valid_in  input  1  data_in valid this cycle; no backpressure.
- Out1  output  data_width  window top-left (row r, col c).
- Out2  output  data_width  window top-right (row r, col c+1).
- Out3  output  data_width  window bottom-left (row r+1, col c).
- Out4  output  data_width  window bottom-right (row r+1, col c+1).
- valid_out  output  1  Out1..Out4 hold a complete window this cycle (one-cycle strobe).
- frame_done  output  1  one-cycle pulse, coincident with valid_out of the last window of a frame.

Behaviour:
- Reset (reset==0 at posedge): col_cnt=0, row_cnt=0, valid_out=0, frame_done=0, Out1..Out4=0, prev_pix=0. Line buffer contents are not cleared; they are don't-care because every location is rewritten before it is read.
- All counters and storage advance only on beats with valid_in==1. Cycles with valid_in==0 change no state except clearing valid_out and frame_done. Gaps of any length are legal anywhere.
- col_cnt counts 0..img_width-1 and wraps to 0, then increments row_cnt. row_cnt counts 0..img_height-1 and wraps to 0. The next frame follows immediately with no idle cycle required.
- Line buffer: img_width x data_width array.
  - Even rows (row_cnt[0]==0): on each beat, linebuf[col_cnt] <= data_in. No output.
  - Odd rows, even col: prev_pix <= data_in. No output.
  - Odd rows, odd col: on the accepting posedge, register Out1<=linebuf[col_cnt-1], Out2<=linebuf[col_cnt], Out3<=prev_pix, Out4<=data_in, valid_out<=1.
- Latency: valid_out asserts on the clock edge that accepts the bottom-right pixel. It is visible the cycle after that pixel is presented (1-cycle latency).
- Outputs hold their last window value while valid_out==0. Consumers must qualify with valid_out.
- Windows per frame: (img_width/2)*(img_height/2). For the default 28x28 frame this is 196 windows, on odd rows only.
- frame_done <= 1 on the same edge as valid_out when row_cnt==img_height-1 and col_cnt==img_width-1. Otherwise 0.
- Back-to-back windows: valid_out can be high at most every other accepted beat within an odd row. It is never high on consecutive cycles.
- Reset mid-frame: the partial frame is discarded and no window is emitted for it. The first beat after reset release is pixel (0,0) of a new frame.
- Pure pass-through: no arithmetic on pixel values. Values are treated as opaque bit patterns, so signed data is passed unchanged.

Test Plan:
- 4x4 frame (img_width=img_height=4), pixels 1..16, valid_in held high -> exactly 4 valid_out strobes: (1,2,5,6), (3,4,7,8), (9,10,13,14), (11,12,15,16). frame_done only with the 4th. Each strobe appears one cycle after pixels 6, 8, 14, 16 are presented.
- Same 4x4 stream with valid_in toggling 1,0,0,1,... (random gaps) -> identical window values and count. No strobe during gap cycles. Outputs hold between strobes.
- Reset (reset=0 for 1 cycle) after pixel 7 of a 4x4 frame, then a fresh 1..16 stream -> no window from the partial frame. The four windows exactly match scenario 1.
- Two consecutive 4x4 frames, 1..16 then 101..116, no idle cycle between -> 8 windows total. 5th window is (101,102,105,106). frame_done pulses twice.
- Default 28x28 frame with pixel = row*28+col, signed negatives at even-row odd columns -> 196 strobes. Window k matches the golden 2x2 gather. Feeding the outputs into the max-pool stage yields the golden pooled map.
- 2x2 minimum frame, pixels 0xFFFFFFFF, 0, 0x80000000, 0x7FFFFFFF -> single window with exactly those bit patterns. frame_done is asserted with it.
